// File: rtl/timer_counter.sv
// Timer counter stage: control fields, 8-bit prescaler, 64-bit free-running counter
// and 64-bit compare value, all updated through byte-strobed register writes.
module timer_counter #(
    parameter int CNT_W   = 64,
    parameter int DIV_MAX = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tcr_wr_sel,
    input  logic             tdr0_wr_sel,
    input  logic             tdr1_wr_sel,
    input  logic             tcmp0_wr_sel,
    input  logic             tcmp1_wr_sel,
    input  logic [31:0]      pwdata,
    input  logic [3:0]       pstrb,
    input  logic             halt_req,
    input  logic             dbg_mode,
    output logic [CNT_W-1:0] cnt,
    output logic [CNT_W-1:0] tcmp,
    output logic             timer_en,
    output logic             div_en,
    output logic [3:0]       div_val,
    output logic             halted,
    output logic             tcr_err
);

    localparam logic [3:0] DIV_LIMIT = 4'(DIV_MAX);

    logic             new_timer_en;
    logic             new_div_en;
    logic [3:0]       new_div_val;
    logic             tcr_load;
    logic             disable_clr;
    logic             running;
    logic [8:0]       presc_limit;
    logic             presc_last;
    logic             tick;
    logic [7:0]       presc;
    logic [7:0]       presc_next;
    logic [CNT_W-1:0] cnt_next;
    logic [CNT_W-1:0] tcmp_next;

    // Effective TCR field values after the write, honouring the byte strobes.
    always_comb begin
        new_timer_en = pstrb[0] ? pwdata[0]    : timer_en;
        new_div_en   = pstrb[0] ? pwdata[1]    : div_en;
        new_div_val  = pstrb[1] ? pwdata[11:8] : div_val;
    end

    assign tcr_err = tcr_wr_sel &
                     ((new_div_val > DIV_LIMIT) |
                      (timer_en & ((new_div_en != div_en) | (new_div_val != div_val))));

    assign tcr_load    = tcr_wr_sel & ~tcr_err;
    assign disable_clr = tcr_load & timer_en & ~new_timer_en;
    assign running     = timer_en & ~halted;
    assign presc_limit = (9'd1 << div_val) - 9'd1;
    assign presc_last  = ({1'b0, presc} == presc_limit);
    assign tick        = running & (~div_en | presc_last);

    always_comb begin
        presc_next = presc;
        if (disable_clr) begin
            presc_next = '0;
        end else if (running) begin
            if (div_en && !presc_last) begin
                presc_next = presc + 8'd1;
            end else begin
                presc_next = '0;
            end
        end
    end

    // A counter write beats a same-cycle tick; unwritten bytes keep the old value.
    always_comb begin
        cnt_next = cnt;
        if (disable_clr) begin
            cnt_next = '0;
        end else if (tdr0_wr_sel || tdr1_wr_sel) begin
            for (int k = 0; k < 4; k++) begin
                if (tdr0_wr_sel && pstrb[k]) begin
                    cnt_next[8*k +: 8] = pwdata[8*k +: 8];
                end
                if (tdr1_wr_sel && pstrb[k]) begin
                    cnt_next[32+8*k +: 8] = pwdata[8*k +: 8];
                end
            end
        end else if (tick) begin
            cnt_next = cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_comb begin
        tcmp_next = tcmp;
        for (int k = 0; k < 4; k++) begin
            if (tcmp0_wr_sel && pstrb[k]) begin
                tcmp_next[8*k +: 8] = pwdata[8*k +: 8];
            end
            if (tcmp1_wr_sel && pstrb[k]) begin
                tcmp_next[32+8*k +: 8] = pwdata[8*k +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            tcmp     <= '1;
            timer_en <= 1'b0;
            div_en   <= 1'b0;
            div_val  <= 4'h1;
            presc    <= '0;
            halted   <= 1'b0;
        end else begin
            cnt    <= cnt_next;
            tcmp   <= tcmp_next;
            presc  <= presc_next;
            halted <= halt_req & dbg_mode;
            if (tcr_load) begin
                timer_en <= new_timer_en;
                div_en   <= new_div_en;
                div_val  <= new_div_val;
            end
        end
    end

endmodule

// File: tb/tb_timer_counter.sv
// Self-checking bench for timer_counter: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model of the timer.
module tb_timer_counter;

    logic        clk;
    logic        rst;
    logic        tcr_wr_sel, tdr0_wr_sel, tdr1_wr_sel, tcmp0_wr_sel, tcmp1_wr_sel;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic        halt_req, dbg_mode;
    logic [63:0] cnt, tcmp;
    logic        timer_en, div_en, halted, tcr_err;
    logic [3:0]  div_val;

    int tests_run = 0;
    int failed    = 0;

    // Behavioural model state
    logic [63:0] m_cnt, m_tcmp;
    logic        m_en, m_den, m_halted;
    logic [3:0]  m_dval;
    int          m_phase;

    timer_counter dut (
        .clk(clk), .rst(rst),
        .tcr_wr_sel(tcr_wr_sel), .tdr0_wr_sel(tdr0_wr_sel), .tdr1_wr_sel(tdr1_wr_sel),
        .tcmp0_wr_sel(tcmp0_wr_sel), .tcmp1_wr_sel(tcmp1_wr_sel),
        .pwdata(pwdata), .pstrb(pstrb), .halt_req(halt_req), .dbg_mode(dbg_mode),
        .cnt(cnt), .tcmp(tcmp), .timer_en(timer_en), .div_en(div_en),
        .div_val(div_val), .halted(halted), .tcr_err(tcr_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic model_err();
        logic       nd;
        logic [3:0] nv;
        if (!tcr_wr_sel) return 1'b0;
        nd = pstrb[0] ? pwdata[1] : m_den;
        nv = pstrb[1] ? pwdata[11:8] : m_dval;
        return (nv > 4'd8) || (m_en && ((nd != m_den) || (nv != m_dval)));
    endfunction

    task automatic model_reset();
        m_cnt = 64'd0; m_tcmp = '1; m_en = 1'b0; m_den = 1'b0;
        m_dval = 4'd1; m_phase = 0; m_halted = 1'b0;
    endtask

    // One clock: the model computes the next state from the current inputs, then the edge.
    task automatic step();
        logic        err, ticked, nen, nden, nhalt;
        logic [3:0]  ndval;
        logic [63:0] ncnt, ntcmp;
        int          nphase, period;
        err    = model_err();
        period = 1 << m_dval;
        ticked = 1'b0;
        nphase = m_phase;
        if (m_en && !m_halted) begin
            if (m_den) begin
                nphase = (m_phase + 1) % period;
                ticked = (nphase == 0);
            end else begin
                nphase = 0;
                ticked = 1'b1;
            end
        end
        ncnt  = ticked ? m_cnt + 64'd1 : m_cnt;
        ntcmp = m_tcmp;
        if (tdr0_wr_sel || tdr1_wr_sel) ncnt = m_cnt;
        for (int k = 0; k < 4; k++) begin
            if (pstrb[k]) begin
                if (tdr0_wr_sel)  ncnt[8*k +: 8]     = pwdata[8*k +: 8];
                if (tdr1_wr_sel)  ncnt[32+8*k +: 8]  = pwdata[8*k +: 8];
                if (tcmp0_wr_sel) ntcmp[8*k +: 8]    = pwdata[8*k +: 8];
                if (tcmp1_wr_sel) ntcmp[32+8*k +: 8] = pwdata[8*k +: 8];
            end
        end
        nen = m_en; nden = m_den; ndval = m_dval;
        if (tcr_wr_sel && !err) begin
            if (pstrb[0]) begin nen = pwdata[0]; nden = pwdata[1]; end
            if (pstrb[1]) ndval = pwdata[11:8];
            if (m_en && !nen) begin ncnt = 64'd0; nphase = 0; end
        end
        nhalt = halt_req && dbg_mode;
        @(posedge clk);
        #1;
        m_cnt = ncnt; m_tcmp = ntcmp; m_en = nen; m_den = nden; m_dval = ndval;
        m_phase = nphase; m_halted = nhalt;
    endtask

    task automatic clear_inputs();
        tcr_wr_sel = 0; tdr0_wr_sel = 0; tdr1_wr_sel = 0; tcmp0_wr_sel = 0; tcmp1_wr_sel = 0;
        pwdata = 32'd0; pstrb = 4'd0;
    endtask

    task automatic set_sel(input int sel);
        tcr_wr_sel   = (sel == 0);
        tdr0_wr_sel  = (sel == 1);
        tdr1_wr_sel  = (sel == 2);
        tcmp0_wr_sel = (sel == 3);
        tcmp1_wr_sel = (sel == 4);
    endtask

    task automatic wr(input int sel, input logic [31:0] d, input logic [3:0] s);
        set_sel(sel);
        pwdata = d;
        pstrb  = s;
        step();
        clear_inputs();
    endtask

    task automatic do_reset();
        clear_inputs();
        halt_req = 0; dbg_mode = 0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++; if (cnt !== 64'd0) begin failed++; $display("[TB] FAIL reset_cnt got=%h exp=0", cnt); end
        tests_run++; if (tcmp !== 64'hFFFF_FFFF_FFFF_FFFF) begin failed++; $display("[TB] FAIL reset_tcmp got=%h exp=all-ones", tcmp); end
        tests_run++; if ({timer_en, div_en, div_val, halted, tcr_err} !== 8'b00_0001_00) begin
            failed++; $display("[TB] FAIL reset_ctrl got=%b exp=00000100", {timer_en, div_en, div_val, halted, tcr_err}); end
    endtask

    task automatic test_count_nodiv();
        do_reset();
        wr(0, 32'h1, 4'b0001);
        for (int i = 0; i < 4; i++) begin
            tests_run++; if (cnt !== 64'(i)) begin failed++; $display("[TB] FAIL nodiv_cnt got=%0d exp=%0d", cnt, i); end
            step();
        end
        tests_run++; if (tcmp !== 64'hFFFF_FFFF_FFFF_FFFF) begin failed++; $display("[TB] FAIL nodiv_tcmp got=%h exp=all-ones", tcmp); end
    endtask

    task automatic test_div_and_err();
        do_reset();
        wr(0, 32'h0000_0203, 4'b0011);
        repeat (40) step();
        tests_run++; if (cnt !== 64'd10) begin failed++; $display("[TB] FAIL div4_cnt got=%0d exp=10", cnt); end
        set_sel(0); pwdata = 32'h0000_0303; pstrb = 4'b0011;
        #1;
        tests_run++; if (tcr_err !== 1'b1) begin failed++; $display("[TB] FAIL err_enabled got=%b exp=1", tcr_err); end
        step(); clear_inputs();
        tests_run++; if (div_val !== 4'd2 || timer_en !== 1'b1) begin
            failed++; $display("[TB] FAIL err_enabled_hold div_val=%0d en=%b exp=2,1", div_val, timer_en); end
        wr(0, 32'h0000_0202, 4'b0011);
        tests_run++; if (cnt !== 64'd0 || timer_en !== 1'b0) begin
            failed++; $display("[TB] FAIL disable_clear cnt=%0d en=%b exp=0,0", cnt, timer_en); end
        set_sel(0); pwdata = 32'h0000_0900; pstrb = 4'b0011;
        #1;
        tests_run++; if (tcr_err !== 1'b1) begin failed++; $display("[TB] FAIL err_divmax got=%b exp=1", tcr_err); end
        step(); clear_inputs();
        tests_run++; if (div_val !== 4'd2) begin failed++; $display("[TB] FAIL err_divmax_hold got=%0d exp=2", div_val); end
    endtask

    task automatic test_wrap();
        do_reset();
        wr(2, 32'hFFFF_FFFF, 4'hF);
        wr(1, 32'hFFFF_FFFE, 4'hF);
        wr(0, 32'h1, 4'b0001);
        tests_run++; if (cnt !== 64'hFFFF_FFFF_FFFF_FFFE) begin failed++; $display("[TB] FAIL wrap0 got=%h exp=FFFFFFFFFFFFFFFE", cnt); end
        step();
        tests_run++; if (cnt !== 64'hFFFF_FFFF_FFFF_FFFF) begin failed++; $display("[TB] FAIL wrap1 got=%h exp=FFFFFFFFFFFFFFFF", cnt); end
        step();
        tests_run++; if (cnt !== 64'd0) begin failed++; $display("[TB] FAIL wrap2 got=%h exp=0", cnt); end
    endtask

    task automatic test_halt();
        do_reset();
        wr(0, 32'h1, 4'b0001);
        repeat (3) step();
        halt_req = 1; dbg_mode = 1;
        step();
        tests_run++; if (cnt !== 64'd4 || halted !== 1'b1) begin failed++; $display("[TB] FAIL halt_enter cnt=%0d halted=%b exp=4,1", cnt, halted); end
        repeat (4) step();
        tests_run++; if (cnt !== 64'd4) begin failed++; $display("[TB] FAIL halt_frozen got=%0d exp=4", cnt); end
        halt_req = 0;
        step();
        tests_run++; if (cnt !== 64'd4 || halted !== 1'b0) begin failed++; $display("[TB] FAIL halt_exit cnt=%0d halted=%b exp=4,0", cnt, halted); end
        step();
        tests_run++; if (cnt !== 64'd5) begin failed++; $display("[TB] FAIL halt_resume got=%0d exp=5", cnt); end
        halt_req = 1; dbg_mode = 0;
        repeat (3) step();
        tests_run++; if (cnt !== 64'd8 || halted !== 1'b0) begin failed++; $display("[TB] FAIL halt_nodbg cnt=%0d halted=%b exp=8,0", cnt, halted); end
        halt_req = 0;
    endtask

    task automatic test_write_vs_tick();
        do_reset();
        wr(1, 32'h0000_01FE, 4'hF);
        wr(0, 32'h1, 4'b0001);
        step();
        tests_run++; if (cnt !== 64'h1FF) begin failed++; $display("[TB] FAIL collide_pre got=%h exp=1ff", cnt); end
        wr(1, 32'h0000_0055, 4'b0001);
        tests_run++; if (cnt !== 64'h155) begin failed++; $display("[TB] FAIL collide got=%h exp=155", cnt); end
        wr(0, 32'h0, 4'b0001);
        tests_run++; if (cnt !== 64'd0 || timer_en !== 1'b0) begin failed++; $display("[TB] FAIL collide_disable cnt=%h en=%b exp=0,0", cnt, timer_en); end
        wr(1, 32'h0000_0077, 4'b0001);
        step();
        tests_run++; if (cnt !== 64'h77) begin failed++; $display("[TB] FAIL disabled_write got=%h exp=77", cnt); end
    endtask

    task automatic test_reset_midcount();
        do_reset();
        wr(3, 32'h1234_5678, 4'hF);
        wr(0, 32'h0000_0003, 4'b0011);
        repeat (5) step();
        #2 rst = 1'b1;
        #1;
        tests_run++; if (cnt !== 64'd0 || tcmp !== 64'hFFFF_FFFF_FFFF_FFFF || timer_en !== 1'b0 || div_val !== 4'd1) begin
            failed++; $display("[TB] FAIL async_reset cnt=%h tcmp=%h en=%b dv=%0d", cnt, tcmp, timer_en, div_val); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    // Random traffic against the model, including back-to-back writes and halts.
    task automatic test_random();
        int r;
        do_reset();
        for (int i = 0; i < 800; i++) begin
            r = $urandom_range(0, 15);
            clear_inputs();
            if (r < 5 && !(r inside {1, 2} && $urandom_range(0, 3) != 0)) begin
                set_sel(r);
                pwdata = $urandom;
                if (r == 0) pwdata[11:8] = 4'($urandom_range(0, 9));
                pstrb = 4'($urandom_range(0, 15));
            end
            halt_req = ($urandom_range(0, 7) == 0);
            dbg_mode = $urandom_range(0, 1) != 0;
            #1;
            tests_run++; if (tcr_err !== model_err()) begin failed++; $display("[TB] FAIL rand_err cyc=%0d got=%b exp=%b", i, tcr_err, model_err()); end
            step();
            tests_run++; if (cnt !== m_cnt || tcmp !== m_tcmp) begin
                failed++; $display("[TB] FAIL rand_regs cyc=%0d cnt=%h exp=%h tcmp=%h exp=%h", i, cnt, m_cnt, tcmp, m_tcmp); end
            tests_run++; if ({timer_en, div_en, div_val, halted} !== {m_en, m_den, m_dval, m_halted}) begin
                failed++; $display("[TB] FAIL rand_ctrl cyc=%0d got=%b exp=%b", i, {timer_en, div_en, div_val, halted}, {m_en, m_den, m_dval, m_halted}); end
        end
        clear_inputs();
        halt_req = 0; dbg_mode = 0;
    endtask

    initial begin
        clear_inputs();
        halt_req = 0; dbg_mode = 0; rst = 1'b1;
        model_reset();
        test_reset();
        test_count_nodiv();
        test_div_and_err();
        test_wrap();
        test_halt();
        test_write_vs_tick();
        test_reset_midcount();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
